// File: rtl/vga_plot_scheduler.sv
// ---------------------------------------------------------------------------
// vga_plot_scheduler
//
// Purpose:
//   Owns the single vga_adapter write port and shares it between NUM_REQ
//   pixel requesters (character sprite, platform drawer, bonus marker).
//   One pixel is granted per cycle in round-robin order and presented on a
//   fully registered output stage. The block can also run a full-screen
//   clear sweep that writes CLEAR_COLOUR to every pixel, row by row.
//
// Ports:
//   clk          system clock
//   resetn       asynchronous, active-low reset
//   req          per-requester pixel request (data held stable while high)
//   req_x        packed x, requester i on [8*i+7:8*i]
//   req_y        packed y, requester i on [7*i+6:7*i]
//   req_colour   packed colour, requester i on [3*i+2:3*i]
//   ack          one-cycle pulse: requester i's pixel was consumed
//   clear_start  pulse: begin a full-screen clear
//   clear_busy   high while clear pixels are being written
//   clear_done   one-cycle pulse after the last clear pixel
//   plot         write strobe to vga_adapter
//   x, y, colour pixel coordinates and colour to vga_adapter
//   dropped      one-cycle pulse: granted pixel was off-screen, not plotted
// ---------------------------------------------------------------------------
module vga_plot_scheduler #(
    parameter int         NUM_REQ      = 3,
    parameter int         X_SIZE       = 160,
    parameter int         Y_SIZE       = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_x,
    input  logic [7*NUM_REQ-1:0] req_y,
    input  logic [3*NUM_REQ-1:0] req_colour,
    output logic [NUM_REQ-1:0]   ack,
    input  logic                 clear_start,
    output logic                 clear_busy,
    output logic                 clear_done,
    output logic                 plot,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 dropped
);

    localparam int         PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] X_LAST = 8'(X_SIZE - 1);
    localparam logic [6:0] Y_LAST = 7'(Y_SIZE - 1);

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [7:0]         clr_x, clr_x_nxt;
    logic [6:0]         clr_y, clr_y_nxt;

    logic [NUM_REQ-1:0] ack_nxt;
    logic               plot_nxt;
    logic [7:0]         x_nxt;
    logic [6:0]         y_nxt;
    logic [2:0]         colour_nxt;
    logic               dropped_nxt;
    logic               clear_busy_nxt;
    logic               clear_done_nxt;

    logic [NUM_REQ-1:0] eligible;
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    int                 cand;

    logic [7:0]         sel_x;
    logic [6:0]         sel_y;
    logic [2:0]         sel_colour;
    logic               sel_in_range;

    // A requester that is being acked this cycle is not eligible again, so a
    // held request is served at most every second cycle and the requester
    // has one cycle to present new data or drop req.
    always_comb begin
        eligible    = req & ~ack;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    // Extract the winner's pixel and check it against the screen bounds.
    always_comb begin
        sel_x        = req_x[8*int'(grant_idx) +: 8];
        sel_y        = req_y[7*int'(grant_idx) +: 7];
        sel_colour   = req_colour[3*int'(grant_idx) +: 3];
        sel_in_range = (sel_x <= X_LAST) && (sel_y <= Y_LAST);
    end

    // Next-state and next-output logic.
    // The first clear pixel (0,0) is issued on the same edge that accepts
    // clear_start, so clr_x/clr_y always hold the pixel currently on the
    // outputs while in CLEAR. Once the last pixel has been shown, one idle
    // cycle carries clear_done and the block is back in ARB.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        clr_x_nxt      = clr_x;
        clr_y_nxt      = clr_y;
        ack_nxt        = '0;
        plot_nxt       = 1'b0;
        x_nxt          = x;
        y_nxt          = y;
        colour_nxt     = colour;
        dropped_nxt    = 1'b0;
        clear_busy_nxt = 1'b0;
        clear_done_nxt = 1'b0;

        case (state)
            ARB: begin
                if (clear_start) begin
                    state_nxt      = CLEAR;
                    clr_x_nxt      = '0;
                    clr_y_nxt      = '0;
                    plot_nxt       = 1'b1;
                    x_nxt          = '0;
                    y_nxt          = '0;
                    colour_nxt     = CLEAR_COLOUR;
                    clear_busy_nxt = 1'b1;
                end else if (grant_found) begin
                    ack_nxt[grant_idx] = 1'b1;
                    x_nxt              = sel_x;
                    y_nxt              = sel_y;
                    colour_nxt         = sel_colour;
                    plot_nxt           = sel_in_range;
                    dropped_nxt        = ~sel_in_range;
                    if (int'(grant_idx) == NUM_REQ - 1) begin
                        ptr_nxt = '0;
                    end else begin
                        ptr_nxt = grant_idx + 1'b1;
                    end
                end
            end

            CLEAR: begin
                if ((clr_x == X_LAST) && (clr_y == Y_LAST)) begin
                    state_nxt      = ARB;
                    clr_x_nxt      = '0;
                    clr_y_nxt      = '0;
                    clear_done_nxt = 1'b1;
                end else begin
                    if (clr_x == X_LAST) begin
                        clr_x_nxt = '0;
                        clr_y_nxt = clr_y + 1'b1;
                    end else begin
                        clr_x_nxt = clr_x + 1'b1;
                    end
                    plot_nxt       = 1'b1;
                    x_nxt          = clr_x_nxt;
                    y_nxt          = clr_y_nxt;
                    colour_nxt     = CLEAR_COLOUR;
                    clear_busy_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointer, clear counters and the registered vga_adapter outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr        <= '0;
            clr_x      <= '0;
            clr_y      <= '0;
            ack        <= '0;
            plot       <= 1'b0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            dropped    <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            ptr        <= ptr_nxt;
            clr_x      <= clr_x_nxt;
            clr_y      <= clr_y_nxt;
            ack        <= ack_nxt;
            plot       <= plot_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            colour     <= colour_nxt;
            dropped    <= dropped_nxt;
            clear_busy <= clear_busy_nxt;
            clear_done <= clear_done_nxt;
        end
    end

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vga_plot_scheduler
//
// Purpose:
//   Self-checking bench for vga_plot_scheduler: a table of single-cycle
//   arbitration vectors followed by hand-written clear-sweep and reset
//   sequences.
// ---------------------------------------------------------------------------
module tb_vga_plot_scheduler;

    logic        clk;
    logic        resetn;
    logic [2:0]  req;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [8:0]  req_colour;
    logic [2:0]  ack;
    logic        clear_start;
    logic        clear_busy;
    logic        clear_done;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        dropped;

    int checks;
    int failures;

    vga_plot_scheduler dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_colour  (req_colour),
        .ack         (ack),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .dropped     (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester pixel sets: {req2, req1, req0}
    localparam logic [23:0] RX_A = {8'd159, 8'd30, 8'd10};
    localparam logic [20:0] RY_A = {7'd119, 7'd85, 7'd20};
    localparam logic [8:0]  RC_A = {3'b111, 3'b100, 3'b001};
    localparam logic [23:0] RX_B = {8'd159, 8'd30, 8'd160};
    localparam logic [20:0] RY_B = {7'd119, 7'd85, 7'd10};
    localparam logic [8:0]  RC_B = {3'b111, 3'b100, 3'b010};
    localparam logic [23:0] RX_C = {8'd159, 8'd30, 8'd5};
    localparam logic [20:0] RY_C = {7'd119, 7'd85, 7'd120};
    localparam logic [8:0]  RC_C = {3'b111, 3'b100, 3'b011};

    typedef struct {
        logic [2:0]  req;
        logic [23:0] rx;
        logic [20:0] ry;
        logic [8:0]  rc;
        logic        cs;
        logic [2:0]  e_ack;
        logic        e_plot;
        logic [7:0]  e_x;
        logic [6:0]  e_y;
        logic [2:0]  e_col;
        logic        e_drop;
    } vec_t;

    localparam int NVEC = 14;
    vec_t tbl[NVEC];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [23:0] rx,
                                 input logic [20:0] ry, input logic [8:0] rc,
                                 input logic cs);
        req         = r;
        req_x       = rx;
        req_y       = ry;
        req_colour  = rc;
        clear_start = cs;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] e_ack,
                               input logic e_plot, input logic [7:0] e_x,
                               input logic [6:0] e_y, input logic [2:0] e_col,
                               input logic e_drop, input logic e_busy,
                               input logic e_done);
        checks++;
        if (ack !== e_ack || plot !== e_plot || x !== e_x || y !== e_y ||
            colour !== e_col || dropped !== e_drop || clear_busy !== e_busy ||
            clear_done !== e_done) begin
            failures++;
            $display("[TB] FAIL %s: got ack=%b plot=%b x=%0d y=%0d col=%b drop=%b busy=%b done=%b, expected ack=%b plot=%b x=%0d y=%0d col=%b drop=%b busy=%b done=%b",
                     name, ack, plot, x, y, colour, dropped, clear_busy, clear_done,
                     e_ack, e_plot, e_x, e_y, e_col, e_drop, e_busy, e_done);
        end
    endtask

    initial begin
        int bad;
        int first_bad;
        checks   = 0;
        failures = 0;

        tbl[0]  = '{3'b010, RX_A, RY_A, RC_A, 1'b0, 3'b010, 1'b1, 8'd30,  7'd85,  3'b100, 1'b0};
        tbl[1]  = '{3'b010, RX_A, RY_A, RC_A, 1'b0, 3'b000, 1'b0, 8'd30,  7'd85,  3'b100, 1'b0};
        tbl[2]  = '{3'b010, RX_A, RY_A, RC_A, 1'b0, 3'b010, 1'b1, 8'd30,  7'd85,  3'b100, 1'b0};
        tbl[3]  = '{3'b000, RX_A, RY_A, RC_A, 1'b0, 3'b000, 1'b0, 8'd30,  7'd85,  3'b100, 1'b0};
        tbl[4]  = '{3'b111, RX_A, RY_A, RC_A, 1'b0, 3'b100, 1'b1, 8'd159, 7'd119, 3'b111, 1'b0};
        tbl[5]  = '{3'b111, RX_A, RY_A, RC_A, 1'b0, 3'b001, 1'b1, 8'd10,  7'd20,  3'b001, 1'b0};
        tbl[6]  = '{3'b111, RX_A, RY_A, RC_A, 1'b0, 3'b010, 1'b1, 8'd30,  7'd85,  3'b100, 1'b0};
        tbl[7]  = '{3'b111, RX_A, RY_A, RC_A, 1'b0, 3'b100, 1'b1, 8'd159, 7'd119, 3'b111, 1'b0};
        tbl[8]  = '{3'b111, RX_A, RY_A, RC_A, 1'b0, 3'b001, 1'b1, 8'd10,  7'd20,  3'b001, 1'b0};
        tbl[9]  = '{3'b000, RX_A, RY_A, RC_A, 1'b0, 3'b000, 1'b0, 8'd10,  7'd20,  3'b001, 1'b0};
        tbl[10] = '{3'b001, RX_B, RY_B, RC_B, 1'b0, 3'b001, 1'b0, 8'd160, 7'd10,  3'b010, 1'b1};
        tbl[11] = '{3'b000, RX_B, RY_B, RC_B, 1'b0, 3'b000, 1'b0, 8'd160, 7'd10,  3'b010, 1'b0};
        tbl[12] = '{3'b001, RX_C, RY_C, RC_C, 1'b0, 3'b001, 1'b0, 8'd5,   7'd120, 3'b011, 1'b1};
        tbl[13] = '{3'b000, RX_C, RY_C, RC_C, 1'b0, 3'b000, 1'b0, 8'd5,   7'd120, 3'b011, 1'b0};

        // Reset state
        resetn = 1'b0;
        applyStimulus(3'b000, RX_A, RY_A, RC_A, 1'b0);
        #1;
        checkOutput("reset_state", 3'b000, 1'b0, 8'd0, 7'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;

        // Table-driven arbitration vectors
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(tbl[i].req, tbl[i].rx, tbl[i].ry, tbl[i].rc, tbl[i].cs);
            step();
            checkOutput($sformatf("vec%0d", i), tbl[i].e_ack, tbl[i].e_plot,
                        tbl[i].e_x, tbl[i].e_y, tbl[i].e_col, tbl[i].e_drop,
                        1'b0, 1'b0);
        end

        // Clear sweep with req0 held; clear_start wins over the request
        applyStimulus(3'b001, RX_A, RY_A, RC_A, 1'b1);
        step();
        checkOutput("clear_first_pixel", 3'b000, 1'b1, 8'd0, 7'd0, 3'b000, 1'b0, 1'b1, 1'b0);
        bad       = 0;
        first_bad = -1;
        for (int i = 1; i < 19200; i++) begin
            clear_start = (i == 3000);
            step();
            if (ack !== 3'b000 || plot !== 1'b1 || clear_busy !== 1'b1 ||
                clear_done !== 1'b0 || colour !== 3'b000 ||
                x !== 8'(i % 160) || y !== 7'(i / 160)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        clear_start = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL clear_sweep: %0d bad pixels, first at index %0d, required 0 bad", bad, first_bad);
        end
        checkOutput("clear_last_pixel", 3'b000, 1'b1, 8'd159, 7'd119, 3'b000, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("clear_done", 3'b000, 1'b0, 8'd159, 7'd119, 3'b000, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("grant_after_clear", 3'b001, 1'b1, 8'd10, 7'd20, 3'b001, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b000, RX_A, RY_A, RC_A, 1'b0);
        step();
        checkOutput("idle_after_clear", 3'b000, 1'b0, 8'd10, 7'd20, 3'b001, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a sweep, at pixel 5000 = (40,31)
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        repeat (5000) step();
        checkOutput("clear_pixel_5000", 3'b000, 1'b1, 8'd40, 7'd31, 3'b000, 1'b0, 1'b1, 1'b0);
        req = 3'b111;
        #2 resetn = 1'b0;
        #1;
        checkOutput("reset_mid_clear", 3'b000, 1'b0, 8'd0, 7'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("reset_held", 3'b000, 1'b0, 8'd0, 7'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        #2 resetn = 1'b1;
        step();
        checkOutput("first_grant_req0", 3'b001, 1'b1, 8'd10, 7'd20, 3'b001, 1'b0, 1'b0, 1'b0);
        req = 3'b000;
        step();
        checkOutput("no_done_after_reset", 3'b000, 1'b0, 8'd10, 7'd20, 3'b001, 1'b0, 1'b0, 1'b0);

        // Fresh sweep restarts from the origin
        clear_start = 1'b1;
        step();
        checkOutput("fresh_clear_0_0", 3'b000, 1'b1, 8'd0, 7'd0, 3'b000, 1'b0, 1'b1, 1'b0);
        clear_start = 1'b0;
        step();
        checkOutput("fresh_clear_1_0", 3'b000, 1'b1, 8'd1, 7'd0, 3'b000, 1'b0, 1'b1, 1'b0);
        repeat (159) step();
        checkOutput("fresh_clear_0_1", 3'b000, 1'b1, 8'd0, 7'd1, 3'b000, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
